// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared types and constants for the instruction-memory responder
// Purpose: FSM state encoding, the NOP instruction word, the legal latency range
//          and the width of the latency counter.
// Ports:   none (package).
package imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Returned on misaligned fetches.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  // Wide enough to hold LATENCY_MAX-1.
  localparam int CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - program storage with one synchronous write port and one read port
// Purpose: 16-bit word storage of 2**DEPTH_LOG2 entries. The data array has no reset.
//          The read is combinational, so a write at an edge is not visible to a
//          read sampled at that same edge (same-cycle read returns the old word).
// Ports:   clk               - clock, rising edge
//          wr_en/wr_idx/wr_data - write port, word index and data
//          rd_idx/rd_data    - read port, word index and data
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [15:0]           wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [15:0]           rd_data
);

  logic [15:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - multi-cycle instruction-memory responder for the fetch stage
// Purpose: accepts a PC over req_valid/req_ready, returns one 16-bit instruction
//          LATENCY edges later over rsp_valid/rsp_ready, with flush, halt and a
//          preload write port into the storage.
// Ports:   clk, rst (async, active low)
//          req_valid/req_ready/req_addr        - fetch request (byte address)
//          rsp_valid/rsp_ready/rsp_instr/rsp_err - response, err on misaligned PC
//          flush - drop in-flight/pending response; halt - block new requests
//          busy  - high whenever the FSM is not idle
//          ld_en/ld_addr/ld_data - preload write (byte address, bit 0 ignored)
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_instr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        halt,
  output logic        busy,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  // Out-of-range LATENCY values are clamped into the legal range.
  localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                       (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      rsp_instr_q, rsp_instr_d;
  logic             rsp_err_q, rsp_err_d;

  logic                  accept;
  logic [15:0]           rsp_addr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [15:0]           rd_data;
  logic                  unused_addr_bits;

  assign accept = req_valid & req_ready;

  // With single-cycle latency the response is built from the request itself
  // at the accept edge; otherwise from the captured address in the last BUSY cycle.
  assign rsp_addr = (LAT == 1) ? req_addr : addr_q;
  assign rd_idx   = rsp_addr[DEPTH_LOG2:1];

  // Address bits above the storage index wrap; bit 0 only flags misalignment.
  assign unused_addr_bits = ^{addr_q, req_addr, ld_addr};

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_addr[DEPTH_LOG2:1]),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      rsp_instr_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;

    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_BUSY: begin
          if (count_q == '0) begin
            state_d     = ST_RESP;
            rsp_err_d   = rsp_addr[0];
            rsp_instr_d = rsp_addr[0] ? NOP_INSTR : rd_data;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // accept only occurs from IDLE, or from RESP in its consume cycle,
      // so it overrides the IDLE return above for back-to-back fetches.
      if (accept) begin
        addr_d  = req_addr;
        count_d = CNT_LOAD;
        if (LAT == 1) begin
          state_d     = ST_RESP;
          rsp_err_d   = rsp_addr[0];
          rsp_instr_d = rsp_addr[0] ? NOP_INSTR : rd_data;
        end else begin
          state_d = ST_BUSY;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    req_ready = ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready)) && !flush && !halt;
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    rsp_instr = rsp_instr_q;
    rsp_err   = rsp_err_q;
  end

endmodule
